// File: rtl/write_to_read_pointer_sync_status.sv
// ---------------------------------------------------------------------------
// write_to_read_pointer_sync_status
//
// Read-domain half of the async FIFO pointer exchange. The write-side Gray
// pointer is carried across SYNC_STAGES flops, decoded to binary in a
// register, and compared with the local binary read pointer to give the
// fill level, empty and almost-empty status.
//
// Parameters
//   ADDR_SIZE          FIFO address bits; pointers are ADDR_SIZE+1 bits wide
//   SYNC_STAGES        synchroniser depth, 2..4
//   ALMOST_EMPTY_LEVEL almost_empty_o is high when fill level <= this value
//
// Ports
//   read_clock_i            in   read-domain clock, rising edge
//   read_reset_i            in   synchronous active-high reset
//   write_pointer_gray_i    in   Gray write pointer from the write domain
//   read_pointer_bin_i      in   local binary read pointer
//   write_to_read_pointer_o out  Gray pointer at the last sync stage
//   write_pointer_bin_o     out  registered binary decode of the synced pointer
//   fill_level_o            out  write_pointer_bin_o - read_pointer_bin_i
//   empty_o                 out  fill level is zero
//   almost_empty_o          out  fill level <= ALMOST_EMPTY_LEVEL
//   pointer_advance_o       out  one-cycle pulse when write_pointer_bin_o changes
//   gray_error_o            out  sticky pointer-integrity error
//
// Optional feature: define WRITE_TO_READ_GRAY_CHECK_EN to build the pointer
// integrity checker. Without it gray_error_o is tied low.
// ---------------------------------------------------------------------------
module write_to_read_pointer_sync_status #(
  parameter int ADDR_SIZE          = 3,
  parameter int SYNC_STAGES        = 2,
  parameter int ALMOST_EMPTY_LEVEL = 1
) (
  input  logic                 read_clock_i,
  input  logic                 read_reset_i,
  input  logic [ADDR_SIZE:0]   write_pointer_gray_i,
  input  logic [ADDR_SIZE:0]   read_pointer_bin_i,
  output logic [ADDR_SIZE:0]   write_to_read_pointer_o,
  output logic [ADDR_SIZE:0]   write_pointer_bin_o,
  output logic [ADDR_SIZE:0]   fill_level_o,
  output logic                 empty_o,
  output logic                 almost_empty_o,
  output logic                 pointer_advance_o,
  output logic                 gray_error_o
);

  localparam int PW = ADDR_SIZE + 1;
  localparam logic [PW-1:0] AE_LEVEL  = PW'(ALMOST_EMPTY_LEVEL);
  localparam logic [PW-1:0] FULL_FILL = PW'(2 ** ADDR_SIZE);

  logic [PW-1:0] r_sync [SYNC_STAGES];
  logic [PW-1:0] r_bin;
  logic          r_advance;
  logic [PW-1:0] w_final_gray;
  logic [PW-1:0] w_decoded;
  logic [PW-1:0] w_fill;

  function automatic logic [PW-1:0] gray_to_bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Synchroniser chain. Every stage is reset so a mid-stream reset discards
  // any pointer value still in flight.
  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples its predecessor's pre-edge value, forming a true shift chain.
  always_ff @(posedge read_clock_i) begin
    if (read_reset_i) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        r_sync[k] <= '0;
      end
    end else begin
      r_sync[0] <= write_pointer_gray_i;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        r_sync[k] <= r_sync[k-1];
      end
    end
  end

  assign w_final_gray = r_sync[SYNC_STAGES-1];
  assign w_decoded    = gray_to_bin(w_final_gray);

  // Binary pointer and its change pulse load on the same edge; a multi-step
  // jump still yields a single pulse because only inequality is tested.
  always_ff @(posedge read_clock_i) begin
    if (read_reset_i) begin
      r_bin     <= '0;
      r_advance <= 1'b0;
    end else begin
      r_bin     <= w_decoded;
      r_advance <= (w_decoded != r_bin);
    end
  end

  // Status is combinational against the live read pointer so a read
  // increment lowers the fill level in the same cycle (errs toward empty).
  // Modulo subtraction handles wrap of either pointer.
  assign w_fill = r_bin - read_pointer_bin_i;

  assign write_to_read_pointer_o = w_final_gray;
  assign write_pointer_bin_o     = r_bin;
  assign pointer_advance_o       = r_advance;
  assign fill_level_o            = w_fill;
  assign empty_o                 = (w_fill == '0);
  assign almost_empty_o          = (w_fill <= AE_LEVEL);

`ifdef WRITE_TO_READ_GRAY_CHECK_EN
  logic [PW-1:0] r_prev_gray;
  logic          r_gray_error;
  logic [PW-1:0] w_gray_diff;
  logic          w_multi_bit;
  logic          w_overfill;

  // x & (x-1) clears the lowest set bit; anything left means >1 bit changed.
  assign w_gray_diff = w_final_gray ^ r_prev_gray;
  assign w_multi_bit = ((w_gray_diff & (w_gray_diff - PW'(1))) != '0);
  assign w_overfill  = (w_fill > FULL_FILL);

  always_ff @(posedge read_clock_i) begin
    if (read_reset_i) begin
      r_prev_gray  <= '0;
      r_gray_error <= 1'b0;
    end else begin
      r_prev_gray <= w_final_gray;
      if (w_multi_bit || w_overfill) begin
        r_gray_error <= 1'b1;
      end
    end
  end

  assign gray_error_o = r_gray_error;
`else
  assign gray_error_o = 1'b0;
`endif

endmodule

// File: tb/tb_write_to_read_pointer_sync_status.sv
module tb_write_to_read_pointer_sync_status;

  localparam int AW = 3;
  localparam int PW = AW + 1;

`ifdef WRITE_TO_READ_GRAY_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [PW-1:0] gray_in;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] sync_out;
  logic [PW-1:0] wbin;
  logic [PW-1:0] fill;
  logic          empty;
  logic          aempty;
  logic          adv;
  logic          gerr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  write_to_read_pointer_sync_status #(
    .ADDR_SIZE(AW), .SYNC_STAGES(2), .ALMOST_EMPTY_LEVEL(1)
  ) dut (
    .read_clock_i           (clk),
    .read_reset_i           (rst),
    .write_pointer_gray_i   (gray_in),
    .read_pointer_bin_i     (rd_ptr),
    .write_to_read_pointer_o(sync_out),
    .write_pointer_bin_o    (wbin),
    .fill_level_o           (fill),
    .empty_o                (empty),
    .almost_empty_o         (aempty),
    .pointer_advance_o      (adv),
    .gray_error_o           (gerr)
  );

  typedef struct {
    logic [PW-1:0] gray;
    logic [PW-1:0] rd;
    logic [PW-1:0] exp_bin;
    logic [PW-1:0] exp_fill;
    logic          exp_empty;
    logic          exp_ae;
  } vec_t;

  vec_t vecs [18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance n rising edges, then step 1 time unit clear of the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  function automatic logic [PW-1:0] b2g(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{4'b0001, 4'd0,  4'd1,  4'd1, 1'b0, 1'b1};
    vecs[1]  = '{4'b0011, 4'd1,  4'd2,  4'd1, 1'b0, 1'b1};
    vecs[2]  = '{4'b0010, 4'd1,  4'd3,  4'd2, 1'b0, 1'b0};
    vecs[3]  = '{4'b0110, 4'd3,  4'd4,  4'd1, 1'b0, 1'b1};
    vecs[4]  = '{4'b0110, 4'd4,  4'd4,  4'd0, 1'b1, 1'b1};
    vecs[5]  = '{4'b0111, 4'd0,  4'd5,  4'd5, 1'b0, 1'b0};
    vecs[6]  = '{4'b0101, 4'd0,  4'd6,  4'd6, 1'b0, 1'b0};
    vecs[7]  = '{4'b0100, 4'd0,  4'd7,  4'd7, 1'b0, 1'b0};
    vecs[8]  = '{4'b1100, 4'd0,  4'd8,  4'd8, 1'b0, 1'b0};
    vecs[9]  = '{4'b1101, 4'd1,  4'd9,  4'd8, 1'b0, 1'b0};
    vecs[10] = '{4'b1111, 4'd9,  4'd10, 4'd1, 1'b0, 1'b1};
    vecs[11] = '{4'b1110, 4'd10, 4'd11, 4'd1, 1'b0, 1'b1};
    vecs[12] = '{4'b1010, 4'd10, 4'd12, 4'd2, 1'b0, 1'b0};
    vecs[13] = '{4'b1011, 4'd12, 4'd13, 4'd1, 1'b0, 1'b1};
    vecs[14] = '{4'b1001, 4'd13, 4'd14, 4'd1, 1'b0, 1'b1};
    vecs[15] = '{4'b1000, 4'd14, 4'd15, 4'd1, 1'b0, 1'b1};
    vecs[16] = '{4'b0000, 4'd14, 4'd0,  4'd2, 1'b0, 1'b0};
    vecs[17] = '{4'b0001, 4'd0,  4'd1,  4'd1, 1'b0, 1'b1};

    // Reset with a non-zero pointer at the input.
    rst = 1'b1; gray_in = 4'b0110; rd_ptr = '0;
    tick(2);
    check("rst_sync",   sync_out, 0);
    check("rst_bin",    wbin,     0);
    check("rst_fill",   fill,     0);
    check("rst_empty",  empty,    1);
    check("rst_aempty", aempty,   1);
    check("rst_adv",    adv,      0);
    check("rst_err",    gerr,     0);

    // First pointer after reset: latency 2 to sync output, 3 to binary.
    rst = 1'b0; gray_in = 4'b0001;
    tick(1);
    check("lat_e1_sync", sync_out, 0);
    tick(1);
    check("lat_e2_sync", sync_out, 4'b0001);
    check("lat_e2_bin",  wbin,     0);
    check("lat_e2_adv",  adv,      0);
    tick(1);
    check("lat_e3_bin",    wbin,   1);
    check("lat_e3_adv",    adv,    1);
    check("lat_e3_fill",   fill,   1);
    check("lat_e3_empty",  empty,  0);
    check("lat_e3_aempty", aempty, 1);
    tick(1);
    check("lat_e4_adv", adv, 0);

    // Settled vectors: legal single-step Gray walk through full and wrap.
    foreach (vecs[i]) begin
      gray_in = vecs[i].gray;
      rd_ptr  = vecs[i].rd;
      tick(4);
      check($sformatf("v%0d_sync", i),   sync_out, vecs[i].gray);
      check($sformatf("v%0d_bin", i),    wbin,     vecs[i].exp_bin);
      check($sformatf("v%0d_fill", i),   fill,     vecs[i].exp_fill);
      check($sformatf("v%0d_empty", i),  empty,    vecs[i].exp_empty);
      check($sformatf("v%0d_aempty", i), aempty,   vecs[i].exp_ae);
      check($sformatf("v%0d_adv", i),    adv,      0);
      check($sformatf("v%0d_err", i),    gerr,     0);
    end

    // Multi-step jump: single advance pulse; Gray jump flags error if built.
    gray_in = 4'b0000; rd_ptr = '0;
    do_reset();
    gray_in = 4'b0011;
    tick(2);
    check("jump_e2_err", gerr, 0);
    tick(1);
    check("jump_e3_bin", wbin, 2);
    check("jump_e3_adv", adv,  1);
    check("jump_e3_err", gerr, CHK);
    tick(1);
    check("jump_e4_adv", adv, 0);
    gray_in = 4'b0010;
    tick(4);
    check("jump_sticky_bin", wbin, 3);
    check("jump_sticky_err", gerr, CHK);
    gray_in = 4'b0000;
    do_reset();
    check("jump_clear_err", gerr, 0);

    // Overfill: legal walk to bin 8 (full), then bin 9 against read 0.
    for (int b = 1; b <= 8; b++) begin
      gray_in = b2g(PW'(b));
      tick(4);
    end
    check("full_fill",   fill,   8);
    check("full_empty",  empty,  0);
    check("full_aempty", aempty, 0);
    check("full_err",    gerr,   0);
    gray_in = b2g(4'd9);
    tick(4);
    check("over_fill", fill, 9);
    check("over_err",  gerr, CHK);

    // Mid-stream reset with bin 5 in flight.
    gray_in = 4'b0000;
    do_reset();
    for (int b = 1; b <= 4; b++) begin
      gray_in = b2g(PW'(b));
      tick(4);
    end
    check("mid_pre_bin", wbin, 4);
    gray_in = 4'b0111;
    tick(1);
    rst = 1'b1; gray_in = 4'b0001;
    tick(1);
    check("mid_rst_sync", sync_out, 0);
    check("mid_rst_bin",  wbin,     0);
    check("mid_rst_adv",  adv,      0);
    check("mid_rst_fill", fill,     0);
    check("mid_rst_err",  gerr,     0);
    rst = 1'b0;
    tick(1);
    check("mid_e1_sync", sync_out, 0);
    check("mid_e1_adv",  adv,      0);
    tick(1);
    check("mid_e2_sync", sync_out, 4'b0001);
    check("mid_e2_bin",  wbin,     0);
    tick(1);
    check("mid_e3_bin", wbin, 1);
    check("mid_e3_adv", adv,  1);
    tick(1);
    check("mid_e4_adv", adv,  0);
    check("mid_e4_err", gerr, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
